// File: rtl/instruction_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INST_W   = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef logic [4:0] opcode_t;

  function automatic opcode_t inst_op(input logic [INST_W-1:0] inst);
    return inst[6:2];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect input and decode output.
// Handshakes: a transfer happens in a cycle where valid && ready at the rising edge; valid may not
// depend on ready, and payload is only meaningful while valid is high. Responses have no ready.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  opcode_t           if_op;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_inst, if_op,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_inst, if_op,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Synchronous fetch buffer with flush; push while full is accepted only alongside a pop.
module instruction_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, credit-limited in-order imem requests, response buffering and redirect drop.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = XLEN + INST_W;

  logic [XLEN-1:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, redirect_base;
  logic [CW-1:0]     out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CW:0]       slots_used;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [INST_W-1:0] head_inst;
  logic              req_valid, accept, rsp, push, pop, redirect;

  assign redirect      = bus.redirect_valid;
  assign redirect_base = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign rsp           = bus.imem_rsp_valid;
  assign pop           = !fifo_empty && bus.if_ready;
  assign push          = rsp && (drop_q == '0) && !redirect;

  // The slot freed by this cycle's pop is reusable at once, so a 1-cycle memory streams at full rate.
  assign slots_used = {1'b0, fifo_count} - (CW+1)'(pop) + {1'b0, out_q};
  assign req_valid  = rst_n && !redirect && (slots_used < (CW+1)'(BUF_DEPTH));
  assign accept     = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;

  assign head_inst   = fifo_empty ? INST_NOP : fifo_head[INST_W-1:0];
  assign bus.if_valid = !fifo_empty;
  assign bus.if_pc    = fifo_empty ? '0 : fifo_head[EW-1:INST_W];
  assign bus.if_inst  = head_inst;
  assign bus.if_op    = inst_op(head_inst);

  // Responses come back in request order, so the PC of the next kept word simply counts up.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CW'(accept) - CW'(rsp);
    drop_d   = drop_q;
    if (redirect) begin
      pc_d     = redirect_base;
      rsp_pc_d = redirect_base;
      drop_d   = out_d;
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  instruction_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({rsp_pc_q, bus.imem_rsp_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n) rsp |-> (out_q != '0));
  a_no_overflow:     assert property (@(posedge clk) disable iff (!rst_n) push |-> (!fifo_full || pop));
  a_credit_limit:    assert property (@(posedge clk) disable iff (!rst_n) accept |-> (out_q < CW'(BUF_DEPTH)));
  a_drop_bounded:    assert property (@(posedge clk) disable iff (!rst_n) drop_q <= out_q);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with programmable latency, decode consumer, scoreboard.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(XLEN)) bus();

  instruction_fetch #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int lat = 1;
  int accepts = 0;
  int pops = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int errors = 0;
  int checks = 0;

  // Memory contents: inst[6:2] equals addr[6:2], so the expected opcode is read straight off the PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:7] ^ 25'h0a5a5a5, a[6:2], 2'b11};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d words never delivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect_to(input logic [31:0] a);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, 64'(bus.if_valid), 64'd0);
    chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    chk({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'h0);
    chk({tag, "_if_inst"}, 64'(bus.if_inst), 64'h13);
    chk({tag, "_if_op"}, 64'(bus.if_op), 64'b00100);
    chk({tag, "_if_pc"}, 64'(bus.if_pc), 64'h0);
  endtask

  // Memory responder and decode consumer, driven just after each rising edge.
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      bus.imem_req_ready = 1'b1;
      bus.if_ready       = (exp_q.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(cyc + lat);
      accepts++;
    end
  end

  // Scoreboard monitor: every decode transfer is matched against the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: got pc %0h, required no transfer", bus.if_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("if_pc", 64'(bus.if_pc), 64'(e[63:32]));
        chk("if_inst", 64'(bus.if_inst), 64'(e[31:0]));
        chk("if_op", 64'(bus.if_op), 64'(e[38:34]));
        if (pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
    end
  end

  initial begin
    int r;
    int n;
    int a0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    // 1: stream from reset with 1-cycle memory
    expect_seq(32'h0, 8);
    pops = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    r = cyc;
    drain("t1", 40);
    chk("t1_first_pop_cycle", 64'(first_pop_cyc), 64'(r + 2));
    chk("t1_last_pop_cycle", 64'(last_pop_cyc), 64'(r + 9));

    // 2: decode stalled, credit limit holds requests
    repeat (10) @(negedge clk);
    #1;
    chk("t2_req_valid_stalled", 64'(bus.imem_req_valid), 64'd0);
    chk("t2_if_valid_stalled", 64'(bus.if_valid), 64'd1);
    chk("t2_head_pc", 64'(bus.if_pc), 64'h20);
    chk("t2_total_accepts", 64'(accepts), 64'd10);
    pops = 0;
    expect_seq(32'h20, 6);
    drain("t2", 40);
    chk("t2_no_bubbles", 64'(last_pop_cyc - first_pop_cyc), 64'd5);

    // 3: 3-cycle memory, redirect with two requests in flight
    repeat (6) @(negedge clk);
    lat = 3;
    expect_seq(32'h38, 2);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (pend_addr.size() != 2 && n < 30);
    chk("t3_two_in_flight", 64'(pend_addr.size()), 64'd2);
    redirect_to(32'h100);
    expect_seq(32'h100, 3);
    drain("t3", 60);

    // 4: back-to-back redirects, misaligned target, no request during redirect
    repeat (8) @(negedge clk);
    lat = 1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    @(posedge clk); #1;
    bus.redirect_pc = 32'h103;
    a0 = accepts;
    @(negedge clk); #1;
    chk("t4_req_valid_in_redirect", 64'(bus.imem_req_valid), 64'd0);
    chk("t4_req_ready_in_redirect", 64'(bus.imem_req_ready), 64'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("t4_no_accept_in_redirect", 64'(accepts), 64'(a0));
    expect_seq(32'h100, 3);
    drain("t4", 40);

    // 5: PC wraps past the top of the address space
    repeat (5) @(negedge clk);
    redirect_to(32'hFFFF_FFF8);
    expect_seq(32'hFFFF_FFF8, 4);
    drain("t5", 40);

    // 6: asynchronous reset mid-burst
    repeat (5) @(negedge clk);
    redirect_to(32'h40);
    pops = 0;
    expect_seq(32'h40, 8);
    n = 0;
    while (pops < 3 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_burst_started", 64'(pops >= 3), 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    pops = 0;
    expect_seq(32'h0, 3);
    #2;
    rst_n = 1'b1;
    r = cyc;
    drain("t6", 40);
    chk("t6_restart_first_pop_cycle", 64'(first_pop_cyc), 64'(r + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
